// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared constants, FSM encoding and helpers for action_select_ctrl
//
// Purpose: single home for the Q-value width, action count, LFSR seed,
// FSM state encoding and the NO_ACTION marker used by the selector.
package ttt_pkg;

    localparam int          Q_W       = 18;
    localparam int          N_ACT     = 9;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [3:0]  NO_ACTION = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Folds an 8-bit random byte onto the action range 0..N_ACT-1.
    function automatic logic [3:0] mod_n_act(input logic [7:0] v);
        return 4'(v % 8'(N_ACT));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
//
// Purpose: pseudo-random source for the exploration roll and candidate cell.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, loads SEED
//   state - current LFSR contents, advances every non-reset cycle
module lfsr16 #(
    parameter logic [15:0] SEED = ttt_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Taps 16,14,13,11 map to bits 15,13,12,10 for a left-shifting register.
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/action_select_ctrl.sv
// rtl/action_select_ctrl.sv - epsilon-greedy action selector over a Q-table row
//
// Purpose: on start, scans all actions of a Q-table row, skipping occupied
// cells, and returns either the argmax legal action or, when the random roll
// falls below epsilon, a pseudo-random legal action. Fixed 11-cycle latency.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - request one selection (accepted only when idle)
//   occupied[N_ACT-1:0]      - bit i set means action i is illegal
//   epsilon[7:0]             - exploration threshold, 0 disables exploration
//   q_rd_en, q_addr[3:0]     - Q-table read strobe and action index
//   q_rd_data[Q_W-1:0]       - signed Q value, one cycle after q_rd_en
//   busy, done               - selection in progress / one-cycle result strobe
//   next_action[3:0]         - chosen action, NO_ACTION when none legal
//   action_valid, explored   - legal result flag / result came from exploration
module action_select_ctrl #(
    parameter int          Q_W       = ttt_pkg::Q_W,
    parameter int          N_ACT     = ttt_pkg::N_ACT,
    parameter logic [15:0] LFSR_SEED = ttt_pkg::LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_ACT-1:0] occupied,
    input  logic [7:0]       epsilon,
    output logic             q_rd_en,
    output logic [3:0]       q_addr,
    input  logic [Q_W-1:0]   q_rd_data,
    output logic             busy,
    output logic             done,
    output logic [3:0]       next_action,
    output logic             action_valid,
    output logic             explored
);

    import ttt_pkg::*;

    localparam logic signed [Q_W-1:0] Q_MIN    = {1'b1, {(Q_W-1){1'b0}}};
    localparam logic [3:0]            LAST_IDX = 4'(N_ACT - 1);

    state_t                 state_q,        state_d;
    logic [3:0]             idx_q,          idx_d;
    logic                   ev_valid_q,     ev_valid_d;
    logic [3:0]             ev_idx_q,       ev_idx_d;
    logic [N_ACT-1:0]       occ_q,          occ_d;
    logic [7:0]             eps_q,          eps_d;
    logic [7:0]             roll_q,         roll_d;
    logic [3:0]             cand_q,         cand_d;
    logic signed [Q_W-1:0]  max_val_q,      max_val_d;
    logic [3:0]             max_idx_q,      max_idx_d;
    logic                   any_q,          any_d;
    logic [3:0]             first_idx_q,    first_idx_d;
    logic                   ge_found_q,     ge_found_d;
    logic [3:0]             ge_idx_q,       ge_idx_d;
    logic [3:0]             next_action_q,  next_action_d;
    logic                   action_valid_q, action_valid_d;
    logic                   explored_q,     explored_d;

    logic [15:0]            lfsr_state;
    logic                   ev_legal;
    logic signed [Q_W-1:0]  q_val;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    assign q_val    = $signed(q_rd_data);
    // The read issued last cycle is the one whose data is on q_rd_data now.
    assign ev_legal = ev_valid_q && !occ_q[ev_idx_q];

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ev_valid_d     = (state_q == ST_SCAN);
        ev_idx_d       = idx_q;
        occ_d          = occ_q;
        eps_d          = eps_q;
        roll_d         = roll_q;
        cand_d         = cand_q;
        max_val_d      = max_val_q;
        max_idx_d      = max_idx_q;
        any_d          = any_q;
        first_idx_d    = first_idx_q;
        ge_found_d     = ge_found_q;
        ge_idx_d       = ge_idx_q;
        next_action_d  = next_action_q;
        action_valid_d = action_valid_q;
        explored_d     = explored_q;

        // Running trackers. Strict '>' keeps the lowest index on ties; the
        // first legal value always seeds the maximum, even if it equals Q_MIN.
        if (ev_legal) begin
            if (!any_q || (q_val > max_val_q)) begin
                max_val_d = q_val;
                max_idx_d = ev_idx_q;
            end
            if (!any_q) begin
                any_d       = 1'b1;
                first_idx_d = ev_idx_q;
            end
            if (!ge_found_q && (ev_idx_q >= cand_q)) begin
                ge_found_d = 1'b1;
                ge_idx_d   = ev_idx_q;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    occ_d       = occupied;
                    eps_d       = epsilon;
                    roll_d      = lfsr_state[7:0];
                    cand_d      = mod_n_act(lfsr_state[15:8]);
                    max_val_d   = Q_MIN;
                    max_idx_d   = 4'd0;
                    any_d       = 1'b0;
                    first_idx_d = 4'd0;
                    ge_found_d  = 1'b0;
                    ge_idx_d    = 4'd0;
                    idx_d       = 4'd0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // The last index is evaluated this cycle, so decide from the
                // freshly updated tracker values rather than the registers.
                if (!any_d) begin
                    next_action_d  = NO_ACTION;
                    action_valid_d = 1'b0;
                    explored_d     = 1'b0;
                end else if (roll_q < eps_q) begin
                    next_action_d  = ge_found_d ? ge_idx_d : first_idx_d;
                    action_valid_d = 1'b1;
                    explored_d     = 1'b1;
                end else begin
                    next_action_d  = max_idx_d;
                    action_valid_d = 1'b1;
                    explored_d     = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= 4'd0;
            ev_valid_q     <= 1'b0;
            ev_idx_q       <= 4'd0;
            occ_q          <= '0;
            eps_q          <= 8'd0;
            roll_q         <= 8'd0;
            cand_q         <= 4'd0;
            max_val_q      <= Q_MIN;
            max_idx_q      <= 4'd0;
            any_q          <= 1'b0;
            first_idx_q    <= 4'd0;
            ge_found_q     <= 1'b0;
            ge_idx_q       <= 4'd0;
            next_action_q  <= NO_ACTION;
            action_valid_q <= 1'b0;
            explored_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ev_valid_q     <= ev_valid_d;
            ev_idx_q       <= ev_idx_d;
            occ_q          <= occ_d;
            eps_q          <= eps_d;
            roll_q         <= roll_d;
            cand_q         <= cand_d;
            max_val_q      <= max_val_d;
            max_idx_q      <= max_idx_d;
            any_q          <= any_d;
            first_idx_q    <= first_idx_d;
            ge_found_q     <= ge_found_d;
            ge_idx_q       <= ge_idx_d;
            next_action_q  <= next_action_d;
            action_valid_q <= action_valid_d;
            explored_q     <= explored_d;
        end
    end

    assign q_rd_en      = (state_q == ST_SCAN);
    assign q_addr       = idx_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign next_action  = next_action_q;
    assign action_valid = action_valid_q;
    assign explored     = explored_q;

endmodule

// File: tb/tb_action_select_ctrl.sv
// tb/tb_action_select_ctrl.sv - scoreboard bench for action_select_ctrl
module tb_action_select_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  occupied;
    logic [7:0]  epsilon;
    logic        q_rd_en;
    logic [3:0]  q_addr;
    logic [17:0] q_rd_data;
    logic        busy;
    logic        done;
    logic [3:0]  next_action;
    logic        action_valid;
    logic        explored;

    action_select_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .occupied     (occupied),
        .epsilon      (epsilon),
        .q_rd_en      (q_rd_en),
        .q_addr       (q_addr),
        .q_rd_data    (q_rd_data),
        .busy         (busy),
        .done         (done),
        .next_action  (next_action),
        .action_valid (action_valid),
        .explored     (explored)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] act;
        logic       valid;
        logic       expl;
    } res_t;

    res_t                exp_q[$];
    logic signed [17:0]  mem [9];
    int                  n_checks = 0;
    int                  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference selection: argmax (lowest index on ties) or epsilon exploration.
    function automatic res_t model(input logic [8:0] occ, input logic [7:0] eps, input logic [15:0] l);
        int   r     = int'(l[7:0]);
        int   cand  = int'(l[15:8]) % 9;
        int   pick  = -1;
        res_t x;
        x = '{4'hF, 1'b0, 1'b0};
        if (occ == 9'h1FF) return x;
        if (r < int'(eps)) begin
            for (int i = cand; i < 9; i++) if (pick < 0 && !occ[i]) pick = i;
            for (int i = 0; i < 9; i++)    if (pick < 0 && !occ[i]) pick = i;
            x = '{4'(pick), 1'b1, 1'b1};
        end else begin
            for (int i = 0; i < 9; i++)
                if (!occ[i] && (pick < 0 || mem[i] > mem[pick])) pick = i;
            x = '{4'(pick), 1'b1, 1'b0};
        end
        return x;
    endfunction

    // Model: phase 0 = idle, k = cycle Ck of an accepted selection (1..11).
    logic [15:0] m_lfsr;
    int          m_phase   = 0;
    bit          m_started = 0;
    int          m_rst_gen = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            if (m_phase >= 1 && m_phase <= 10 && exp_q.size() > 0) void'(exp_q.pop_back());
            m_phase = 0;
            m_lfsr  = 16'hACE1;
            m_rst_gen++;
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    exp_q.push_back(model(occupied, epsilon, m_lfsr));
                    m_phase = 1;
                end
            end else if (m_phase == 11) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    // Q-table responder: data for a read appears in the following cycle only.
    bit         pend = 0;
    logic [3:0] pend_addr = 4'd0;
    always @(negedge clk) begin
        if (pend) q_rd_data = mem[pend_addr];
        else      q_rd_data = 18'($urandom);
        pend      = q_rd_en;
        pend_addr = q_addr;
    end

    // Monitor: timing against the model, results popped from the scoreboard.
    res_t held = '{4'hF, 1'b0, 1'b0};
    int   seen_gen = 0;
    res_t e;
    always @(negedge clk) begin
        if (m_started) begin
            if (m_rst_gen != seen_gen) begin
                seen_gen = m_rst_gen;
                held     = '{4'hF, 1'b0, 1'b0};
            end
            check("busy", busy, m_phase != 0);
            check("q_rd_en", q_rd_en, m_phase >= 1 && m_phase <= 9);
            if (m_phase >= 1 && m_phase <= 9) check("q_addr", q_addr, m_phase - 1);
            check("done", done, m_phase == 11);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done with empty scoreboard (t=%0t)", $time);
                end else begin
                    e    = exp_q.pop_front();
                    held = e;
                end
            end
            check("next_action", next_action, held.act);
            check("action_valid", action_valid, held.valid);
            check("explored", explored, held.expl);
        end
    end

    task automatic issue(input logic [8:0] occ, input logic [7:0] eps);
        occupied = occ;
        epsilon  = eps;
        start    = 1'b1;
    endtask

    // Returns the number of negedges from the issuing cycle (C0) to done.
    task automatic wait_done(input bit hold, output res_t r, output int lat);
        bit got = 0;
        lat = -1;
        r   = '0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                got = 1;
                lat = k;
                r   = '{next_action, action_valid, explored};
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_done: no done within 40 cycles (t=%0t)", $time);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (m_phase == 0) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_idle: selection did not finish (t=%0t)", $time);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   lat;
        int   seen;
        bit   found;
        rst = 1'b1; start = 1'b0; occupied = '0; epsilon = '0;
        for (int i = 0; i < 9; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_q_rd_en", q_rd_en, 0);
        check("rst_q_addr", q_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_next_action", next_action, 4'hF);
        check("rst_action_valid", action_valid, 0);
        check("rst_explored", explored, 0);
        rst = 1'b0;
        @(negedge clk);

        // Argmax with a tie: lowest index wins.
        mem = '{18'sd5, 18'sd9, -18'sd3, 18'sd9, 18'sd0, 18'sd1, 18'sd2, 18'sd3, 18'sd4};
        issue(9'h000, 8'd0);
        wait_done(0, r, lat);
        check("t1_latency", lat, 11);
        check("t1_action", r.act, 1);
        check("t1_valid", r.valid, 1);
        check("t1_explored", r.expl, 0);
        @(negedge clk);

        // Occupied maximum is skipped.
        issue(9'b000000010, 8'd0);
        wait_done(0, r, lat);
        check("t2_action", r.act, 3);
        check("t2_explored", r.expl, 0);
        @(negedge clk);

        // Board full.
        issue(9'h1FF, 8'hFF);
        wait_done(0, r, lat);
        check("t3_latency", lat, 11);
        check("t3_action", r.act, 4'hF);
        check("t3_valid", r.valid, 0);
        check("t3_explored", r.expl, 0);
        @(negedge clk);

        // Exploration with candidate 7, cells 7 and 8 occupied: wraps to 0.
        for (int i = 0; i < 9; i++) mem[i] = 18'($urandom);
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            if ((int'(m_lfsr[15:8]) % 9) == 7 && m_lfsr[7:0] != 8'hFF) found = 1;
            else @(negedge clk);
        end
        check("t4_cand_search", found, 1);
        issue(9'b110000000, 8'hFF);
        wait_done(0, r, lat);
        check("t4_action", r.act, 0);
        check("t4_valid", r.valid, 1);
        check("t4_explored", r.expl, 1);
        @(negedge clk);

        // Reset in C5 aborts the scan; a fresh start still takes 11 cycles.
        mem = '{18'sd1, 18'sd2, 18'sd3, 18'sd4, 18'sd5, 18'sd6, 18'sd7, 18'sd8, 18'sd0};
        issue(9'h000, 8'd0);
        for (int k = 0; k < 20 && m_phase != 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5_abort_q_rd_en", q_rd_en, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("t5_abort_no_done", seen, 0);
        issue(9'h000, 8'd0);
        wait_done(0, r, lat);
        check("t5_restart_latency", lat, 11);
        check("t5_restart_action", r.act, 7);
        @(negedge clk);

        // Start held through DONE, all-negative Q values.
        mem = '{-18'sd5, -18'sd2, -18'sd9, -18'sd2, -18'sd100, 18'h20000, -18'sd3, -18'sd7, -18'sd2};
        issue(9'h000, 8'd0);
        wait_done(1, r, lat);
        check("t6_latency", lat, 11);
        check("t6_action", r.act, 1);
        @(negedge clk);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_done", done, 0);
        wait_done(1, r, lat);
        check("t6_second_latency", lat, 11);
        check("t6_second_action", r.act, 1);
        start = 1'b0;
        @(negedge clk);
        wait_idle();

        // Randomized selections, checked by the monitor against the model.
        for (int n = 0; n < 60; n++) begin
            logic [8:0] occ;
            logic [7:0] eps;
            for (int i = 0; i < 9; i++)
                mem[i] = ($urandom_range(0, 1) == 1) ? 18'($urandom)
                                                      : 18'($urandom_range(0, 4)) - 18'd2;
            occ = 9'($urandom) & 9'($urandom);
            if ($urandom_range(0, 7) == 0) occ = 9'h1FF;
            case ($urandom_range(0, 2))
                0:       eps = 8'd0;
                1:       eps = 8'hFF;
                default: eps = 8'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(occ, eps);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 14)) @(negedge clk);
            else @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/action_select_ctrl.md
ACTION_SELECT_CTRL -- requirements
Module: action_select_ctrl

Interface
REQ-001 SHALL have parameter Q_W, default 18, Q-value width (two's-complement signed).
REQ-002 SHALL have parameter N_ACT, default 9, number of board cells/actions.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request one action selection; sampled only in IDLE.
REQ-007 SHALL have port occupied  input  9  bit i=1 means cell i illegal; sampled with start.
REQ-008 SHALL have port epsilon  input  8  exploration threshold; sampled with start; 0 disables exploration.
REQ-009 SHALL have port q_rd_en  output  1  Q-table read strobe.
REQ-010 SHALL have port q_addr  output  4  action index read (0..8).
REQ-011 SHALL have port q_rd_data  input  Q_W  Q value, valid exactly one cycle after q_rd_en.
REQ-012 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-014 SHALL have port next_action  output  4  chosen action index, held until next done.
REQ-015 SHALL have port action_valid  output  1  a legal action was chosen; held with next_action.
REQ-016 SHALL have port explored  output  1  result came from exploration, not argmax; held with next_action.

Function
REQ-017 SHALL implement FSM IDLE -> SCAN (9 cycles) -> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-018 SHALL, with start sampled high in IDLE at cycle C0, latch occupied, epsilon and roll r = lfsr[7:0], cand = lfsr[15:8] mod 9.
REQ-019 SHALL assert q_rd_en in C1..C9 with q_addr = 0..8 consecutively; q_rd_en low otherwise.
REQ-020 SHALL evaluate q_rd_data in C2..C10 for index 0..8; skip occupied indices.
REQ-021 SHALL track signed running maximum; replace only on strictly greater value (ties -> lowest index).
REQ-022 SHALL track first legal index >= cand and first legal index overall.
REQ-023 SHALL pulse done in C11 (latency 11 cycles start-to-done) and update next_action/action_valid/explored in that same cycle.
REQ-024 SHALL select exploration when r < epsilon: next_action = first legal index >= cand, else first legal index overall (cyclic wrap); explored=1.
REQ-025 SHALL otherwise output argmax legal index, explored=0.
REQ-026 SHALL, when all 9 cells occupied, output next_action=4'hF, action_valid=0, explored=0, done still pulsed.
REQ-027 SHALL ignore start while not in IDLE (no queuing); start in DONE cycle is ignored.
REQ-028 SHALL advance the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) every cycle when not in reset.
REQ-029 SHALL treat max Q value as most negative (18'h20000) before first legal read.

Reset
REQ-030 SHALL, on rst high at any edge including mid-scan, enter IDLE and abort selection without done.
REQ-031 SHALL reset outputs: q_rd_en=0, q_addr=0, busy=0, done=0, next_action=4'hF, action_valid=0, explored=0; LFSR=LFSR_SEED.

Structure
REQ-032 SHALL place Q_W, N_ACT, LFSR_SEED, FSM state encodings and the NO_ACTION (4'hF) constant in shared package ttt_pkg.
REQ-033 SHALL instantiate one sub-module lfsr16 (seedable, synchronous reset, free-running).

Verification
REQ-034 SHALL test: epsilon=0, occupied=0, Q=[5,9,-3,9,0,1,2,3,4] -> done at C11, next_action=1, action_valid=1, explored=0.
REQ-035 SHALL test: epsilon=0, occupied=9'b000000010, same Q -> next_action=3 (occupied max skipped).
REQ-036 SHALL test: occupied=9'h1FF -> done at C11, next_action=4'hF, action_valid=0.
REQ-037 SHALL test: epsilon=8'hFF forced r=0, cand=7, occupied cells 7,8 -> next_action=0, explored=1 (wrap).
REQ-038 SHALL test: rst asserted at C5 -> q_rd_en low next cycle, no done, restart completes in 11 cycles.
REQ-039 SHALL test: start held high through DONE -> exactly one selection per IDLE acceptance, busy/done timing unchanged, all negative Q values -> correct argmax.
